fdiv_seq: RTL and testbench
===========================

Name: fdiv_seq

Overview:
Multi-cycle single-precision divider built directly downstream of the combinational finv unit.
- Computes q = x1 / x2 as x1 * finv(x2).
- finv is instantiated unchanged, ports (x, y, ovf); a registered rounding multiplier consumes its output.
- Sits in the FPU issue path behind a valid/ready handshake; one operation in flight.

Parameters:
LAT_HOLD, 0, extra idle cycles inserted in S_MUL before S_DONE (0..3), for scheduler timing alignment.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
x1  in  32  dividend, IEEE-754 single
x2  in  32  divisor, IEEE-754 single
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
q  out  32  quotient
ovf  out  1  result overflowed to infinity

Behaviour:
- Reset (rstn low, asynchronous):
  - state=S_IDLE, in_ready=1, out_valid=0, q=0, ovf=0.
  - Internal operand/inverse registers cleared.
  - Reset mid-operation abandons the op; no output is produced for it.
- FSM:
  - S_IDLE: in_ready=1. When in_valid & in_ready, latch x1, x2 and go to S_INV.
  - S_INV: x2 register drives finv. Register inv=finv.y and iovf=finv.ovf. Go to S_MUL.
  - S_MUL: 24x24 mantissa product, normalize, round, register q/ovf. After LAT_HOLD extra cycles, go to S_DONE.
  - S_DONE: out_valid=1. q/ovf held stable until out_ready. On out_ready, go to S_IDLE and drop out_valid the next cycle.
- in_ready is 0 in every state except S_IDLE; there is no accept in the cycle out_valid falls.
- Latency: 3+LAT_HOLD cycles from accept edge to out_valid high. Throughput: one op per 4+LAT_HOLD cycles when out_ready is held high.
- Multiply rules (operand a=x1, b=inv):
  - Sign = s1 ^ s2.
  - Mantissas {1,m} (24 bit); product is 48 bit.
  - If product bit 47 is set, shift right 1 and add 1 to the exponent.
  - Exponent e = e1 + ei - 127, computed 10-bit signed.
  - Round: add the bit below the 23-bit LSB (round half up). Mantissa carry-out increments the exponent.
  - e >= 255: q = {s, 8'hFF, 23'd0}, ovf=1.
  - e <= 0: q = {s, 31'd0} (flush to zero), ovf=0.
- Special cases (checked in S_INV, override the multiply):
  - x2 exponent 0 (zero/denormal): q = ±inf, ovf=1.
  - x1 exponent 0: q = ±0, ovf=0. The x2 check wins when both apply.
  - x2 exponent 255: q = ±0, ovf=0.
  - x1 exponent 255 (x2 normal): q = ±inf, ovf=1.
  - iovf=1 from finv: q = ±inf, ovf=1.
  - NaN payloads are not propagated.
- Accuracy: within ±4 ulp of the IEEE quotient (bitwise) for all normal operands whose result is normal.
- Simultaneous events:
  - in_valid while busy is ignored; the upstream holds it.
  - out_ready asserted early (before S_DONE) has no effect.

Optional Feature:
FDIV_DIVZERO_EN
- Defined: adds output port dz (1 bit), reset 0.
  - dz=1 with out_valid when the x2 exponent is 0 and x1 is nonzero.
  - dz is held with q; ovf still 1 in that case.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Normal division: x1=0x40C00000 (6.0), x2=0x40000000 (2.0), out_ready=1 -> q=0x40400000 (3.0) ±4 ulp, ovf=0, out_valid exactly 3 cycles after accept (LAT_HOLD=0).
- Divide by zero: x1=0x3F800000, x2=0x00000000 -> q=0x7F800000, ovf=1; dz=1 under FDIV_DIVZERO_EN. Repeat with x1=0x00000000 -> q=0x7F800000, ovf=1, dz=0.
- Result overflow/underflow: x1=0x7F000000, x2=0x00800000 -> q=0x7F800000, ovf=1. x1=0x00800000, x2=0x7F000000 -> q=0x00000000, ovf=0.
- Sign handling: x1=0xC1200000 (-10.0), x2=0x40A00000 (5.0) -> q=0xC0000000 (-2.0) ±4 ulp.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q/ovf stable, in_ready=0. Raise out_ready -> out_valid low next cycle, in_ready=1, second op accepted and correct.
- Reset mid-op: deassert rstn during S_MUL -> out_valid=0, in_ready=1 immediately. After release, a new op 1.0/4.0 gives q=0x3E800000 ±4 ulp.

Source files
------------

// File: rtl/fdiv_seq.sv
// ---------------------------------------------------------------------------
// fdiv_seq : multi-cycle single-precision divider, q = x1 * finv(x2).
//
// One operation in flight behind a valid/ready handshake:
//   S_IDLE -> S_INV (reciprocal registered) -> S_MUL (rounded product
//   registered, plus LAT_HOLD idle cycles) -> S_DONE (result held until
//   out_ready).
//
// Parameters:
//   LAT_HOLD  extra idle cycles spent in S_MUL before S_DONE (0..3)
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operands valid          in_ready   block can accept operands
//   x1         dividend (IEEE single)  x2         divisor (IEEE single)
//   out_valid  result valid            out_ready  consumer accepts result
//   q          quotient                ovf        result overflowed to inf
//   dz         divide-by-zero flag (only when FDIV_DIVZERO_EN is defined)
//
// Optional feature macro: FDIV_DIVZERO_EN
// ---------------------------------------------------------------------------

// Combinational reciprocal. Zero/denormal inputs give +-inf with ovf=1,
// inf/NaN inputs give +-0, and reciprocals too small to be normal are
// flushed to +-0.
module finv (
    input  logic [31:0] x,
    output logic [31:0] y,
    output logic        ovf
);
    logic [7:0]        e;
    logic [23:0]       m;
    logic [48:0]       r_full;
    logic [25:0]       r;
    logic signed [9:0] ey;
    logic              unused_r;

    always_comb begin
        e        = x[30:23];
        m        = {1'b1, x[22:0]};
        // 2^48 / m lies in (2^24, 2^25) for a non-power-of-two mantissa,
        // so bit 24 is the hidden one and bit 0 is the rounding bit.
        r_full   = 49'h1_0000_0000_0000 / {25'd0, m};
        r        = r_full[25:0];
        unused_r = ^{r_full[48:24]};
        y        = {x[31], 31'd0};
        ovf      = 1'b0;
        ey       = '0;
        if (e == 8'd0) begin
            y   = {x[31], 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (e == 8'hFF) begin
            y = {x[31], 31'd0};
        end else if (x[22:0] == 23'd0) begin
            ey = 10'sd254 - $signed({2'b00, e});
            if (ey > 10'sd0)
                y = {x[31], ey[7:0], 23'd0};
        end else begin
            ey = 10'sd253 - $signed({2'b00, e});
            // r never gets close enough to 2^25 for this increment to carry.
            if (ey > 10'sd0)
                y = {x[31], ey[7:0], r[23:1] + {22'd0, r[0]}};
        end
    end
endmodule

module fdiv_seq #(
    parameter int LAT_HOLD = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic        ovf
`ifdef FDIV_DIVZERO_EN
    ,output logic       dz
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_INV, S_MUL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] x1_q, x2_q, inv_q, q_q, q_d;
    logic        iovf_q, ovf_q, ovf_d;
    logic [1:0]  hold_q;
    logic        sp_hit_q, sp_hit_d, sp_inf_q, sp_inf_d;
    logic [31:0] finv_y;
    logic        finv_ovf;
`ifdef FDIV_DIVZERO_EN
    logic        dz_hit_d, dz_hit_q, dz_q;
`endif

    finv u_finv (
        .x   (x2_q),
        .y   (finv_y),
        .ovf (finv_ovf)
    );

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_INV;
            S_INV:   state_d = S_MUL;
            S_MUL:   if (hold_q == 2'(LAT_HOLD)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign ovf       = ovf_q;
`ifdef FDIV_DIVZERO_EN
    assign dz        = dz_q;
`endif

    // ---------------- special-operand screen (S_INV) ----------------
    // Priority: zero/denormal divisor, zero/denormal dividend, inf/NaN
    // divisor, inf/NaN dividend.
    always_comb begin
        sp_hit_d = 1'b1;
        sp_inf_d = 1'b0;
        if (x2_q[30:23] == 8'd0)
            sp_inf_d = 1'b1;
        else if (x1_q[30:23] == 8'd0)
            sp_inf_d = 1'b0;
        else if (x2_q[30:23] == 8'hFF)
            sp_inf_d = 1'b0;
        else if (x1_q[30:23] == 8'hFF)
            sp_inf_d = 1'b1;
        else
            sp_hit_d = 1'b0;
`ifdef FDIV_DIVZERO_EN
        dz_hit_d = (x2_q[30:23] == 8'd0) && (x1_q[30:0] != 31'd0);
`endif
    end

    // ---------------- rounding multiplier (S_MUL) ----------------
    logic [47:0]       prod;
    logic [23:0]       mant_r;
    logic signed [9:0] e_raw, e_fin;
    logic              sgn;
    logic              unused_prod;

    always_comb begin
        sgn         = x1_q[31] ^ inv_q[31];
        prod        = {1'b1, x1_q[22:0]} * {1'b1, inv_q[22:0]};
        unused_prod = ^prod[21:0];
        e_raw       = $signed({2'b00, x1_q[30:23]}) + $signed({2'b00, inv_q[30:23]})
                      - 10'sd127 + $signed({9'd0, prod[47]});
        // Keep 23 fraction bits below the leading one, round half up.
        if (prod[47])
            mant_r = {1'b0, prod[46:24]} + {23'd0, prod[23]};
        else
            mant_r = {1'b0, prod[45:23]} + {23'd0, prod[22]};
        // A carry out leaves mant_r[22:0] all zero, so only the exponent moves.
        e_fin = e_raw + $signed({9'd0, mant_r[23]});

        q_d   = {sgn, e_fin[7:0], mant_r[22:0]};
        ovf_d = 1'b0;
        if (sp_hit_q) begin
            q_d   = sp_inf_q ? {sgn, 8'hFF, 23'd0} : {sgn, 31'd0};
            ovf_d = sp_inf_q;
        end else if (iovf_q) begin
            q_d   = {sgn, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (inv_q[30:23] == 8'd0) begin
            // Reciprocal was flushed to zero by finv.
            q_d = {sgn, 31'd0};
        end else if (e_fin >= 10'sd255) begin
            q_d   = {sgn, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            q_d = {sgn, 31'd0};
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            x1_q     <= '0;
            x2_q     <= '0;
            inv_q    <= '0;
            iovf_q   <= 1'b0;
            sp_hit_q <= 1'b0;
            sp_inf_q <= 1'b0;
            hold_q   <= '0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
`ifdef FDIV_DIVZERO_EN
            dz_hit_q <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (in_valid) begin
                    x1_q <= x1;
                    x2_q <= x2;
                end
                S_INV: begin
                    inv_q    <= finv_y;
                    iovf_q   <= finv_ovf;
                    sp_hit_q <= sp_hit_d;
                    sp_inf_q <= sp_inf_d;
                    hold_q   <= '0;
`ifdef FDIV_DIVZERO_EN
                    dz_hit_q <= dz_hit_d;
`endif
                end
                S_MUL: begin
                    q_q    <= q_d;
                    ovf_q  <= ovf_d;
                    hold_q <= hold_q + 2'd1;
`ifdef FDIV_DIVZERO_EN
                    dz_q   <= dz_hit_q;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_fdiv_seq : scoreboard bench for fdiv_seq. The driver pushes the
// reference quotient (exact integer division of the mantissas, rounded)
// for every accepted operation; the monitor pops and compares on each
// output handshake, and also checks latency, hold stability and the
// out_valid/in_ready turnaround.
// ---------------------------------------------------------------------------
module tb_fdiv_seq;
    localparam int LAT_HOLD = 0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] x1 = '0, x2 = '0;
    logic        in_ready, out_valid, ovf;
    logic [31:0] q;
`ifdef FDIV_DIVZERO_EN
    logic        dz;
`endif

    fdiv_seq #(.LAT_HOLD(LAT_HOLD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .ovf       (ovf)
`ifdef FDIV_DIVZERO_EN
        ,.dz       (dz)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a, b, q;
        logic        ovf, dz, approx;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0;

    task automatic chk(string name, bit ok, logic [31:0] act, logic [31:0] want);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference quotient straight from the division rules.
    function automatic exp_t ref_div(logic [31:0] a, logic [31:0] b);
        exp_t r;
        int e1, e2, e;
        bit s;
        longint unsigned m1, m2, quot, mant;
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        s  = a[31] ^ b[31];
        r.a = a; r.b = b; r.ovf = 1'b0; r.dz = 1'b0; r.approx = 1'b0; r.acc = 0;
        r.q = {s, 31'd0};
        if (e2 == 0) begin
            r.q = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; r.dz = (a[30:0] != 31'd0);
        end else if (e1 == 0 || e2 == 255) begin
            r.q = {s, 31'd0};
        end else if (e1 == 255) begin
            r.q = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
        end else begin
            m1   = longint'({1'b1, a[22:0]});
            m2   = longint'({1'b1, b[22:0]});
            quot = (m1 << 26) / m2;
            e    = e1 - e2 + 127;
            if (quot >= (64'd1 << 26)) mant = (quot >> 3) + ((quot >> 2) & 1);
            else begin
                mant = (quot >> 2) + ((quot >> 1) & 1);
                e--;
            end
            if (mant >= (64'd1 << 24)) begin mant = mant >> 1; e++; end
            if (e >= 255) begin
                r.q = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.q = {s, 31'd0};
            end else begin
                r.q = {s, 8'(e), 23'(mant)}; r.approx = 1'b1;
            end
        end
        return r;
    endfunction

    // ---------------- out_ready driver ----------------
    bit rdy_mode = 1'b0;
    bit rdy_val  = 1'b1;
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // ---------------- monitor ----------------
    bit          seen = 1'b0, after_hs = 1'b0;
    logic [31:0] hq;
    logic        hovf;

    always @(negedge clk) begin
        if (!rstn) begin
            seen = 1'b0;
            after_hs = 1'b0;
        end else begin
            if (after_hs) begin
                chk("drop_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
                chk("ready_back", in_ready == 1'b1, 32'(in_ready), 32'd1);
                after_hs = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1'b0, q, 32'hx);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        hq   = q;
                        hovf = ovf;
                        chk("latency", (cyc + 1 - sb[0].acc) == 3 + LAT_HOLD,
                            32'(cyc + 1 - sb[0].acc), 32'(3 + LAT_HOLD));
                    end else begin
                        chk("hold_stable", q == hq && ovf == hovf, q, hq);
                    end
                    chk("busy_not_ready", in_ready == 1'b0, 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        exp_t e;
                        int   d;
                        e = sb.pop_front();
                        if (e.approx) begin
                            d = int'({1'b0, q[30:0]}) - int'({1'b0, e.q[30:0]});
                            chk("q_approx", q[31] == e.q[31] && d <= 4 && d >= -4, q, e.q);
                        end else begin
                            chk("q_exact", q == e.q, q, e.q);
                        end
                        chk("ovf", ovf == e.ovf, 32'(ovf), 32'(e.ovf));
`ifdef FDIV_DIVZERO_EN
                        chk("dz", dz == e.dz, 32'(dz), 32'(e.dz));
`endif
                        seen = 1'b0;
                        after_hs = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(logic [31:0] a, logic [31:0] b);
        int   k = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; x1 = a; x2 = b;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = ref_div(a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x1 = $urandom; x2 = $urandom;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin @(negedge clk); k++; end
        chk("drain", sb.size() == 0, 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] rnd_f(int elo, int ehi);
        logic [31:0] v;
        v = {1'($urandom), 8'($urandom_range(ehi, elo)), 23'($urandom)};
        return v;
    endfunction

    function automatic logic [31:0] rnd_sp();
        logic [31:0] v;
        int k;
        k = $urandom_range(0, 3);
        v = rnd_f(80, 175);
        if (k == 0) v[30:23] = 8'd0;
        if (k == 1) v[30:23] = 8'hFF;
        if (k <= 1 && $urandom_range(0, 1) == 1) v[22:0] = 23'd0;
        return v;
    endfunction

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready == 1'b1, 32'(in_ready), 32'd1);
        chk("rst_out_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
        chk("rst_q", q == 32'd0, q, 32'd0);
        chk("rst_ovf", ovf == 1'b0, 32'(ovf), 32'd0);
        rstn = 1'b1;

        // Directed cases
        issue(32'h40C00000, 32'h40000000);   // 6 / 2
        issue(32'h3F800000, 32'h00000000);   // 1 / 0
        issue(32'h00000000, 32'h00000000);   // 0 / 0
        issue(32'h7F000000, 32'h00800000);   // overflow
        issue(32'h00800000, 32'h7F000000);   // underflow
        issue(32'hC1200000, 32'h40A00000);   // -10 / 5
        issue(32'h7F800000, 32'h40000000);   // inf / 2
        issue(32'h40000000, 32'h7F800000);   // 2 / inf
        drain();

        // Backpressure: five stalled cycles, then a second op
        rdy_val = 1'b0;
        issue(32'h3FC00000, 32'h40400000);   // 1.5 / 3
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        chk("bp_valid_seen", out_valid == 1'b1, 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", in_ready == 1'b0, 32'(in_ready), 32'd0);
        rdy_val = 1'b1;
        issue(32'h41200000, 32'h40800000);   // 10 / 4
        drain();

        // Reset during S_MUL abandons the op
        issue(32'h40000000, 32'h3F800000);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, 32'(out_valid), 32'd0);
        chk("midrst_in_ready", in_ready == 1'b1, 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        issue(32'h3F800000, 32'h40800000);   // 1 / 4
        drain();

        // Random normal operands with random consumer stalls
        rdy_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(rnd_f(80, 175), rnd_f(80, 175));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 24; i++)
            issue(rnd_sp(), rnd_sp());
        drain();
        rdy_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
